// File: rtl/conv_sequencer.sv
// Loop sequencer for the 4x4-kernel CONV datapath: kernel-load and fMap-stream address/strobe generation.
// Optional cycle counter on out_perf_cycles is built when CONV_SEQ_PERF_EN is defined.
module conv_sequencer #(
    parameter int FMAP_W       = 64,
    parameter int KSIZE        = 4,
    parameter int COLS_PER_CYC = 2,
    parameter int MAX_CH       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_start_conv,
    input  logic [2:0]  in_cfg_ci,
    input  logic [2:0]  in_cfg_co,
    input  logic        in_stall,
    output logic        out_knl_load,
    output logic [13:0] out_knl_addr,
    output logic        out_data_valid,
    output logic [16:0] out_fmap_addr,
    output logic [4:0]  out_col_idx,
    output logic [5:0]  out_row_idx,
    output logic [4:0]  out_chnl_idx,
    output logic [4:0]  out_knl_idx,
    output logic        out_first_chnl,
    output logic        out_last_chnl,
    output logic        out_busy,
    output logic        out_end_conv,
    output logic [31:0] out_perf_cycles
);

    localparam int ROW_LAST = FMAP_W - KSIZE;
    localparam int COL_LAST = FMAP_W / COLS_PER_CYC - 1;
    localparam int PLANE    = FMAP_W * FMAP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_STREAM,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    // Config code n selects 8*(n+1) channels, saturating at MAX_CH; returns count-1.
    function automatic logic [4:0] ch_last(input logic [2:0] code);
        int n;
        n = 8 * (int'(code) + 1);
        if (n > MAX_CH) begin
            n = MAX_CH;
        end else begin
            n = n;
        end
        return 5'(n - 1);
    endfunction

    state_t      state_q, state_d;
    logic        h_q, h_d;
    logic [4:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [4:0]  chnl_q, chnl_d;
    logic [4:0]  knl_q, knl_d;
    logic [4:0]  ci_last_q, ci_last_d;
    logic [4:0]  co_last_q, co_last_d;
    logic [13:0] knl_addr_q, knl_addr_d;
    logic [16:0] fmap_addr_q, fmap_addr_d;
    logic        knl_load_q, knl_load_d;
    logic        data_valid_q, data_valid_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        end_q, end_d;
    logic        active_d;
    logic [9:0]  kbase_d;

    // Next-state: loop counters advance one position per unstalled cycle
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        col_d     = col_q;
        row_d     = row_q;
        chnl_d    = chnl_q;
        knl_d     = knl_q;
        ci_last_d = ci_last_q;
        co_last_d = co_last_q;
        case (state_q)
            S_IDLE: begin
                if (in_start_conv) begin
                    ci_last_d = ch_last(in_cfg_ci);
                    co_last_d = ch_last(in_cfg_co);
                    h_d       = 1'b0;
                    col_d     = 5'd0;
                    row_d     = 6'd0;
                    chnl_d    = 5'd0;
                    knl_d     = 5'd0;
                    state_d   = S_KLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_KLOAD: begin
                if (in_stall) begin
                    state_d = S_KLOAD;
                end else if (!h_q) begin
                    h_d = 1'b1;
                end else begin
                    h_d     = 1'b0;
                    col_d   = 5'd0;
                    row_d   = 6'd0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_stall) begin
                    state_d = S_STREAM;
                end else if (col_q != 5'(COL_LAST)) begin
                    col_d = col_q + 5'd1;
                end else begin
                    col_d = 5'd0;
                    if (row_q != 6'(ROW_LAST)) begin
                        row_d = row_q + 6'd1;
                    end else begin
                        row_d   = 6'd0;
                        state_d = S_KLOAD;
                        if (chnl_q != ci_last_q) begin
                            chnl_d = chnl_q + 5'd1;
                        end else begin
                            chnl_d = 5'd0;
                            if (knl_q != co_last_q) begin
                                knl_d = knl_q + 5'd1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (in_start_conv) begin
                    state_d = S_WAIT_LOW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the position being entered, so every output is a flop
    always_comb begin
        active_d     = (state_d == S_KLOAD) || (state_d == S_STREAM);
        kbase_d      = 10'(knl_d) * (10'(ci_last_d) + 10'd1) + 10'(chnl_d);
        knl_addr_d   = {kbase_d, h_d, 3'b000};
        fmap_addr_d  = 17'(chnl_d) * 17'(PLANE) + 17'(row_d) * 17'(FMAP_W)
                     + 17'(col_d) * 17'(COLS_PER_CYC);
        knl_load_d   = (state_d == S_KLOAD);
        data_valid_d = (state_d == S_STREAM);
        first_d      = active_d && (chnl_d == 5'd0);
        last_d       = active_d && (chnl_d == ci_last_d);
        busy_d       = active_d || (state_d == S_DONE);
        end_d        = (state_d == S_DONE);
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            h_q          <= 1'b0;
            col_q        <= 5'd0;
            row_q        <= 6'd0;
            chnl_q       <= 5'd0;
            knl_q        <= 5'd0;
            ci_last_q    <= 5'd0;
            co_last_q    <= 5'd0;
            knl_addr_q   <= 14'd0;
            fmap_addr_q  <= 17'd0;
            knl_load_q   <= 1'b0;
            data_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            col_q        <= col_d;
            row_q        <= row_d;
            chnl_q       <= chnl_d;
            knl_q        <= knl_d;
            ci_last_q    <= ci_last_d;
            co_last_q    <= co_last_d;
            knl_addr_q   <= knl_addr_d;
            fmap_addr_q  <= fmap_addr_d;
            knl_load_q   <= knl_load_d;
            data_valid_q <= data_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            end_q        <= end_d;
        end
    end

    // A stalled cycle must not be consumed downstream, hence the combinational mask
    assign out_knl_load   = knl_load_q & ~in_stall;
    assign out_data_valid = data_valid_q & ~in_stall;
    assign out_knl_addr   = knl_addr_q;
    assign out_fmap_addr  = fmap_addr_q;
    assign out_col_idx    = col_q;
    assign out_row_idx    = row_q;
    assign out_chnl_idx   = chnl_q;
    assign out_knl_idx    = knl_q;
    assign out_first_chnl = first_q;
    assign out_last_chnl  = last_q;
    assign out_busy       = busy_q;
    assign out_end_conv   = end_q;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter, stalls included; held after completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else if ((state_q == S_IDLE) && in_start_conv) begin
            perf_q <= 32'd0;
        end else if (busy_q) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign out_perf_cycles = perf_q;
`else
    assign out_perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a loop-level model queues every expected strobe, a monitor pops and compares.
module tb_conv_sequencer;

    localparam int F      = 8;
    localparam int PER_CH = 2 + (F - 3) * (F / 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start_conv = 1'b0;
    logic [2:0]  in_cfg_ci = 3'd0;
    logic [2:0]  in_cfg_co = 3'd0;
    logic        in_stall = 1'b0;
    logic        out_knl_load;
    logic [13:0] out_knl_addr;
    logic        out_data_valid;
    logic [16:0] out_fmap_addr;
    logic [4:0]  out_col_idx;
    logic [5:0]  out_row_idx;
    logic [4:0]  out_chnl_idx;
    logic [4:0]  out_knl_idx;
    logic        out_first_chnl;
    logic        out_last_chnl;
    logic        out_busy;
    logic        out_end_conv;
    logic [31:0] out_perf_cycles;

    conv_sequencer #(.FMAP_W(F)) dut (
        .clk(clk), .rst_n(rst_n), .in_start_conv(in_start_conv),
        .in_cfg_ci(in_cfg_ci), .in_cfg_co(in_cfg_co), .in_stall(in_stall),
        .out_knl_load(out_knl_load), .out_knl_addr(out_knl_addr),
        .out_data_valid(out_data_valid), .out_fmap_addr(out_fmap_addr),
        .out_col_idx(out_col_idx), .out_row_idx(out_row_idx),
        .out_chnl_idx(out_chnl_idx), .out_knl_idx(out_knl_idx),
        .out_first_chnl(out_first_chnl), .out_last_chnl(out_last_chnl),
        .out_busy(out_busy), .out_end_conv(out_end_conv),
        .out_perf_cycles(out_perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;       // 0 kernel load, 1 stream, 2 end pulse
        int knl_addr;
        int fmap_addr;
        int col;
        int row;
        int chnl;
        int knl;
        int first;
        int last;
    } ev_t;

    ev_t sbq[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ch_of(input int code);
        return (code > 3) ? 32 : 8 * (code + 1);
    endfunction

    // Reference: the nested kernel/channel/row/column walk written directly as loops
    task automatic push_run(input int ci_code, input int co_code);
        int ci_n;
        int co_n;
        ev_t e;
        ci_n = ch_of(ci_code);
        co_n = ch_of(co_code);
        for (int k = 0; k < co_n; k++) begin
            for (int c = 0; c < ci_n; c++) begin
                for (int h = 0; h < 2; h++) begin
                    e = '{0, (k * ci_n + c) * 16 + h * 8, 0, 0, 0, c, k,
                          int'(c == 0), int'(c == ci_n - 1)};
                    sbq.push_back(e);
                end
                for (int r = 0; r <= F - 4; r++) begin
                    for (int cl = 0; cl < F / 2; cl++) begin
                        e = '{1, 0, c * F * F + r * F + 2 * cl, cl, r, c, k,
                              int'(c == 0), int'(c == ci_n - 1)};
                        sbq.push_back(e);
                    end
                end
            end
        end
        e = '{2, 0, 0, 0, 0, 0, 0, 0, 0};
        sbq.push_back(e);
    endtask

    // Monitor: every presented strobe or end pulse must match the head of the queue
    always @(negedge clk) begin
        ev_t e;
        int  ak;
        bit  bad;
        if (rst_n === 1'b1 && (out_knl_load === 1'b1 || out_data_valid === 1'b1 || out_end_conv === 1'b1)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got load=%0d valid=%0d end=%0d expected none",
                         out_knl_load, out_data_valid, out_end_conv);
            end else begin
                e   = sbq.pop_front();
                ak  = out_end_conv ? 2 : (out_knl_load ? 0 : 1);
                bad = (ak != e.kind) || (out_knl_load && out_data_valid) || (out_busy !== 1'b1);
                if (e.kind == 0) begin
                    bad = bad || int'(out_knl_addr) != e.knl_addr || int'(out_chnl_idx) != e.chnl
                        || int'(out_knl_idx) != e.knl || int'(out_first_chnl) != e.first
                        || int'(out_last_chnl) != e.last;
                end else if (e.kind == 1) begin
                    bad = bad || int'(out_fmap_addr) != e.fmap_addr || int'(out_col_idx) != e.col
                        || int'(out_row_idx) != e.row || int'(out_chnl_idx) != e.chnl
                        || int'(out_knl_idx) != e.knl || int'(out_first_chnl) != e.first
                        || int'(out_last_chnl) != e.last;
                end else begin
                    bad = bad || out_knl_load || out_data_valid;
                end
                if (bad) begin
                    errors++;
                    $display("FAIL seq_event: got kind=%0d kaddr=%0d faddr=%0d col=%0d row=%0d ch=%0d k=%0d first=%0d last=%0d busy=%0d expected kind=%0d kaddr=%0d faddr=%0d col=%0d row=%0d ch=%0d k=%0d first=%0d last=%0d",
                             ak, out_knl_addr, out_fmap_addr, out_col_idx, out_row_idx, out_chnl_idx,
                             out_knl_idx, out_first_chnl, out_last_chnl, out_busy,
                             e.kind, e.knl_addr, e.fmap_addr, e.col, e.row, e.chnl, e.knl, e.first, e.last);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        @(negedge clk);
        check(name, {31'd0, |{out_knl_load, out_knl_addr, out_data_valid, out_fmap_addr,
                              out_col_idx, out_row_idx, out_chnl_idx, out_knl_idx,
                              out_first_chnl, out_last_chnl, out_busy, out_end_conv,
                              out_perf_cycles}}, 32'd0);
    endtask

    // One conversion; stall_mode 0 none, 1 random, 2 five-cycle burst at stream col 2.
    // abort_work>0 pulls rst_n after that many consumed positions.
    task automatic run_conv(input int ci_code, input int co_code, input int stall_mode, input int abort_work);
        int ci_n;
        int co_n;
        int work;
        int done_w;
        int stalls;
        bit st;
        ci_n   = ch_of(ci_code);
        co_n   = ch_of(co_code);
        work   = ci_n * co_n * PER_CH;
        done_w = 0;
        stalls = 0;
        push_run(ci_code, co_code);
        in_cfg_ci     = 3'(ci_code);
        in_cfg_co     = 3'(co_code);
        in_start_conv = 1'b1;
        in_stall      = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        in_cfg_ci = 3'($urandom_range(0, 7));
        in_cfg_co = 3'($urandom_range(0, 7));
        while (done_w < work) begin
            if (abort_work > 0 && done_w == abort_work) begin
                rst_n         = 1'b0;
                in_start_conv = 1'b0;
                in_stall      = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                sbq.delete();
                check_all_zero("abort_outputs_zero");
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("abort_no_end", {31'd0, out_end_conv}, 32'd0);
                end
                @(posedge clk);
                #1;
                return;
            end
            case (stall_mode)
                1:       st = ($urandom_range(0, 3) == 0);
                2:       st = (done_w == 4 && stalls < 5);
                default: st = 1'b0;
            endcase
            in_stall = st;
            if (stall_mode == 2 && st) begin
                @(negedge clk);
                check("stall_col_hold", {27'd0, out_col_idx}, 32'd2);
                check("stall_valid_low", {31'd0, out_data_valid}, 32'd0);
            end
            @(posedge clk);
            #1;
            if (st) stalls++;
            else done_w++;
        end
        in_stall = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check("end_pulse_timing", {31'd0, out_end_conv}, 32'd1);
        check("busy_at_end", {31'd0, out_busy}, 32'd1);
        @(posedge clk);
        #1;
        in_stall = 1'b0;
        @(negedge clk);
        check("end_single_pulse", {31'd0, out_end_conv}, 32'd0);
        check("busy_after_end", {31'd0, out_busy}, 32'd0);
`ifdef CONV_SEQ_PERF_EN
        check("perf_cycles", out_perf_cycles, 32'(work + stalls + 1));
`else
        check("perf_cycles", out_perf_cycles, 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_start_no_retrigger", {30'd0, out_knl_load, out_busy}, 32'd0);
        in_start_conv = 1'b0;
        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all_zero("reset_outputs_zero");
        run_conv(0, 0, 0, 0);
        run_conv(3, 1, 1, 0);
        run_conv(0, 0, 2, 0);
        run_conv(6, 0, 1, 0);
        run_conv(0, 2, 1, 2 * 8 * PER_CH + 7);
        run_conv(1, 0, 1, 0);
        run_conv($urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
